// File: rtl/mips_pkg.sv
// Shared constants for the instruction-fetch slice: reset vector, memory
// geometry, instruction width and sequential PC step.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          IMEM_ADDR_W      = 9;
  localparam int          INSN_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/pc_reg.sv
// Next-PC priority mux and the pc_r register.
// Priority: reset > hold > redirect > stall > sequential increment.
// i_hold freezes the PC while the fetch stage has no valid instruction
// (the cycle after reset release, or a sticky fault), so the word that is
// already being read is the first one delivered as valid.
module pc_reg #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_DEFAULT,
  parameter int          ADDR_W   = mips_pkg::IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_hold,
  input  logic              i_redirect,
  input  logic [31:0]       i_target,
  input  logic              i_stall,
  output logic [31:0]       o_pc,
  output logic [ADDR_W-1:0] o_word_addr
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // Select the address the memory reads at the coming edge.
  always_comb begin
    w_pc_next = r_pc + mips_pkg::PC_STEP;
    if (reset) begin
      w_pc_next = RESET_PC;
    end else if (i_hold) begin
      w_pc_next = r_pc;
    end else if (i_redirect) begin
      w_pc_next = i_target;
    end else if (i_stall) begin
      w_pc_next = r_pc;
    end
  end

  // pc_r tracks the address whose data the memory returns this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Upper PC bits are dropped here, so the word address wraps naturally.
  assign o_word_addr = w_pc_next[ADDR_W+1:2];
  assign o_pc        = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a one-cycle synchronous instruction
// memory. Optional feature macro: IFETCH_MISALIGN_TRAP_EN (when defined, a
// redirect to a non word-aligned target raises a sticky fetch_fault and
// freezes fetch until reset; otherwise the target's low two bits are
// cleared and fetch_fault is constant 0).
//
// Handshake: if_valid is the producer's valid, ~stall is the consumer's
// ready. An instruction is transferred on every edge with if_valid=1 and
// stall=0; while stalled, if_instr/if_pc/if_valid are held stable because
// the memory re-reads the same word. redirect overrides stall.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = mips_pkg::RESET_PC_DEFAULT,
  parameter int          IMEM_ADDR_W = mips_pkg::IMEM_ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  output logic [IMEM_ADDR_W-1:0]        imem_addr,
  input  logic [mips_pkg::INSN_W-1:0]   imem_dout,
  output logic [mips_pkg::INSN_W-1:0]   if_instr,
  output logic [31:0]                   if_pc,
  output logic [31:0]                   if_pc4,
  output logic                          if_valid,
  output logic [31:0]                   fetch_cnt,
  output logic                          fetch_fault
);

  logic        r_valid;
  logic        r_fault;
  logic [31:0] r_fetch_cnt;
  logic        w_misalign;
  logic        w_hold;
  logic [31:0] w_target;
  logic [31:0] w_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
  // A misaligned redirect only counts while a valid instruction is live.
  assign w_misalign = r_valid & redirect & (redirect_pc[1:0] != 2'b00);
  assign w_target   = redirect_pc;
`else
  assign w_misalign = 1'b0;
  assign w_target   = redirect_pc & ~32'h0000_0003;
`endif

  // Freeze the PC while no valid instruction exists or a fault is raised.
  assign w_hold = ~r_valid | w_misalign;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .ADDR_W   (IMEM_ADDR_W)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .i_hold      (w_hold),
    .i_redirect  (redirect),
    .i_target    (w_target),
    .i_stall     (stall),
    .o_pc        (w_pc),
    .o_word_addr (imem_addr)
  );

  // Valid rises on the first edge after reset release and drops on a fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= ~(r_fault | w_misalign);
    end
  end

  // Sticky misaligned-redirect fault, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_misalign) begin
      r_fault <= 1'b1;
    end
  end

  // Count instructions handed downstream (valid and not stalled).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= 32'd0;
    end else if (r_valid && !stall) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign if_instr    = imem_dout;
  assign if_pc       = w_pc;
  assign if_pc4      = w_pc + mips_pkg::PC_STEP;
  assign if_valid    = r_valid;
  assign fetch_cnt   = r_fetch_cnt;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_instr_fetch;

  localparam int AW    = 9;
  localparam int DEPTH = 512;
`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic [31:0]   if_pc4;
  logic          if_valid;
  logic [31:0]   fetch_cnt;
  logic          fetch_fault;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_valid    (if_valid),
    .fetch_cnt   (fetch_cnt),
    .fetch_fault (fetch_fault)
  );

  // Instruction memory: one-cycle synchronous read.
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) imem_dout <= mem[imem_addr];

  // ---------------- reference model ----------------
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  bit          m_valid = 1'b0;
  bit          m_fault = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one clock edge given the sampled inputs.
  task automatic predict(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                         output logic [31:0] n_pc, output logic [31:0] n_cnt,
                         output bit n_valid, output bit n_fault);
    n_pc = m_pc; n_cnt = m_cnt; n_valid = m_valid; n_fault = m_fault;
    if (rst) begin
      n_pc = 32'd0; n_cnt = 32'd0; n_valid = 1'b0; n_fault = 1'b0;
    end else if (!m_fault) begin
      if (!m_valid) begin
        n_valid = 1'b1;                    // first fetch becomes valid, PC stays
      end else begin
        if (!st) n_cnt = m_cnt + 1;
        if (rd) begin
          if (TRAP && rpc[1:0] != 2'b00) begin
            n_fault = 1'b1; n_valid = 1'b0;
          end else begin
            n_pc = {rpc[31:2], 2'b00};
          end
        end else if (!st) begin
          n_pc = m_pc + 4;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("if_pc", if_pc, m_pc);
    check("if_pc4", if_pc4, m_pc + 32'd4);
    check("fetch_cnt", fetch_cnt, m_cnt);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    if (m_valid) check("if_instr", if_instr, mem[(m_pc >> 2) % DEPTH]);
  endtask

  // Driver: apply inputs at the falling edge, clock once, check after.
  task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
    logic [31:0] n_pc, n_cnt;
    bit          n_valid, n_fault;
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    predict(rst, st, rd, rpc, n_pc, n_cnt, n_valid, n_fault);
    #1;
    check("imem_addr", 32'(imem_addr), 32'((n_pc >> 2) % DEPTH));
    @(posedge clk);
    m_pc = n_pc; m_cnt = n_cnt; m_valid = n_valid; m_fault = n_fault;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 32'd0);
    step(1, 0, 0, 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] rpc;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_0000;

    @(negedge clk);
    do_reset();
    step(1, 0, 0, 32'd0);
    check("reset_valid", 32'(if_valid), 32'd0);
    check("reset_cnt", fetch_cnt, 32'd0);
    check("reset_pc", if_pc, 32'd0);

    // Reset release: one invalid cycle, then 0/4/8/12 in order.
    reset = 1'b0;
    #1;
    check("release_invalid", 32'(if_valid), 32'd0);
    step(0, 0, 0, 32'd0);
    check("seq_pc0", if_pc, 32'd0);
    check("seq_instr0", if_instr, 32'h2008_0005);
    step(0, 0, 0, 32'd0);
    check("seq_instr4", if_instr, 32'h2009_0003);
    step(0, 0, 0, 32'd0);
    check("seq_instr8", if_instr, 32'h0109_5020);
    step(0, 0, 0, 32'd0);
    check("seq_pc12", if_pc, 32'd12);
    check("seq_instr12", if_instr, 32'h0000_0000);
    step(0, 0, 0, 32'd0);
    check("seq_cnt4", fetch_cnt, 32'd4);

    // Stall for three cycles at pc 4.
    do_reset();
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    check("stall_start_pc", if_pc, 32'd4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'd0);
      check("stall_instr", if_instr, 32'h2009_0003);
      check("stall_cnt", fetch_cnt, 32'd1);
      check("stall_pc", if_pc, 32'd4);
    end
    step(0, 0, 0, 32'd0);
    check("stall_drop_pc", if_pc, 32'd8);

    // Redirect together with stall at pc 8 -> 4.
    step(0, 1, 1, 32'd4);
    check("rd_stall_pc", if_pc, 32'd4);
    check("rd_stall_instr", if_instr, 32'h2009_0003);
    check("rd_stall_valid", 32'(if_valid), 32'd1);
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    check("rd_pre_pc", if_pc, 32'd12);

    // Redirect to 0 at pc 12: no bubble.
    step(0, 0, 1, 32'd0);
    check("rd_pc", if_pc, 32'd0);
    check("rd_instr", if_instr, 32'h2008_0005);
    check("rd_valid", 32'(if_valid), 32'd1);

    // Misaligned redirect.
    step(0, 0, 1, 32'h0000_0006);
    if (TRAP) begin
      check("trap_fault", 32'(fetch_fault), 32'd1);
      check("trap_valid", 32'(if_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h10);
        check("trap_hold_fault", 32'(fetch_fault), 32'd1);
        check("trap_hold_valid", 32'(if_valid), 32'd0);
      end
      step(1, 0, 0, 32'd0);
      check("trap_clear", 32'(fetch_fault), 32'd0);
    end else begin
      check("align_pc", if_pc, 32'd4);
      check("align_fault", 32'(fetch_fault), 32'd0);
    end

    // Run across the top of the word-address space.
    do_reset();
    step(0, 0, 0, 32'd0);
    step(0, 0, 1, 32'h0000_07F4);
    step(0, 0, 0, 32'd0);
    check("wrap_pc7f8", if_pc, 32'h0000_07F8);
    #1;
    check("wrap_addr511", 32'(imem_addr), 32'd511);
    step(0, 0, 0, 32'd0);
    check("wrap_pc7fc", if_pc, 32'h0000_07FC);
    #1;
    check("wrap_addr0", 32'(imem_addr), 32'd0);
    step(0, 0, 0, 32'd0);
    check("wrap_pc800", if_pc, 32'h0000_0800);
    check("wrap_instr", if_instr, 32'h2008_0005);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rpc = 32'($urandom_range(0, 32'h1FFF));
      if ($urandom_range(0, 7) != 0) rpc = rpc & ~32'h3;
      if ($urandom_range(0, 15) == 0) rpc = $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
